// File: rtl/alu_pkg.sv
// Shared encodings and defaults for the ALU result sequencer.
package alu_pkg;

  localparam int unsigned W_DEF           = 16;
  localparam int unsigned RD_W_DEF        = 4;
  localparam int unsigned DIV_TIMEOUT_DEF = 24;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_DIV = 3'd6,
    OP_REM = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_HOLD     = 2'd3
  } ctrl_state_e;

  function automatic logic is_div_op(input alu_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_div_timer.sv
// Clear/enable up-counter that saturates at TERMINAL-1 and flags it.
module alu_div_timer #(
  parameter int unsigned TERMINAL = 24,
  parameter int unsigned CW       = $clog2(TERMINAL)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc_c
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tc_c  = (count_q == CW'(TERMINAL - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc_c) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_result_ctrl.sv
// Sequences one ALU op at a time: starts the divider if needed, captures the
// selected result and holds it for register writeback under valid/ready.
module alu_result_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W           = W_DEF,
  parameter int unsigned RD_W        = RD_W_DEF,
  parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            ISSUE_VALID,
  output logic            ISSUE_READY,
  input  logic [2:0]      ISSUE_OP,
  input  logic [RD_W-1:0] ISSUE_RD,
  input  logic [W-1:0]    S,
  input  logic [W-1:0]    D,
  input  logic [W-1:0]    P,
  input  logic [W-1:0]    AND_OUT,
  input  logic [W-1:0]    OR_OUT,
  input  logic [W-1:0]    XOR_OUT,
  input  logic [2*W-1:0]  DIV_Q,
  input  logic            DIV_QVALID,
  output logic            DIV_START,
  output logic            WB_VALID,
  input  logic            WB_READY,
  output logic [RD_W-1:0] WB_RD,
  output logic [W-1:0]    WB_DATA,
  output logic [W-1:0]    WB_REM,
  output logic            WB_ZERO,
  output logic            WB_ERR
);

  localparam int unsigned TW = $clog2(DIV_TIMEOUT);

  ctrl_state_e     state_q, state_d;
  alu_op_e         op_q, op_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            div_start_q, div_start_d;
  logic            wb_valid_q, wb_valid_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [W-1:0]    wb_data_q, wb_data_d;
  logic [W-1:0]    wb_rem_q, wb_rem_d;
  logic            wb_zero_q, wb_zero_d;
  logic            wb_err_q, wb_err_d;

  logic [TW-1:0]   timer;
  logic            timer_tc_c;
  logic            timer_clr_c;
  logic            timer_en_c;
  logic [W-1:0]    sel_result_c;
  logic [W-1:0]    div_quo_c;
  logic [W-1:0]    div_rem_c;
  logic            qvalid_ok_c;
  alu_op_e         issue_op_c;

  assign issue_op_c  = alu_op_e'(ISSUE_OP);
  assign div_quo_c   = DIV_Q[2*W-1:W];
  assign div_rem_c   = DIV_Q[W-1:0];
  assign timer_clr_c = (state_q != ST_DIV_WAIT);
  assign timer_en_c  = (state_q == ST_DIV_WAIT);
  // A valid seen on the entry cycle may belong to an aborted op, so it is ignored.
  assign qvalid_ok_c = DIV_QVALID && (timer != '0);

  alu_div_timer #(
    .TERMINAL (DIV_TIMEOUT),
    .CW       (TW)
  ) u_div_timer (
    .clk   (CLK),
    .rst_n (RST_N),
    .clr   (timer_clr_c),
    .en    (timer_en_c),
    .count (timer),
    .tc_c  (timer_tc_c)
  );

  // Single-cycle result select for the latched op.
  always_comb begin
    sel_result_c = '0;
    case (op_q)
      OP_ADD:  sel_result_c = S;
      OP_SUB:  sel_result_c = D;
      OP_MUL:  sel_result_c = P;
      OP_AND:  sel_result_c = AND_OUT;
      OP_OR:   sel_result_c = OR_OUT;
      OP_XOR:  sel_result_c = XOR_OUT;
      default: sel_result_c = '0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    div_start_d = 1'b0;
    wb_valid_d  = wb_valid_q;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    wb_rem_d    = wb_rem_q;
    wb_zero_d   = wb_zero_q;
    wb_err_d    = wb_err_q;

    case (state_q)
      ST_IDLE: begin
        if (ISSUE_VALID) begin
          op_d = issue_op_c;
          rd_d = ISSUE_RD;
          if (is_div_op(issue_op_c)) begin
            state_d     = ST_DIV_WAIT;
            div_start_d = 1'b1;
          end else begin
            state_d = ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        wb_data_d  = sel_result_c;
        wb_rem_d   = '0;
        wb_zero_d  = (sel_result_c == '0);
        wb_err_d   = 1'b0;
        state_d    = ST_HOLD;
      end

      ST_DIV_WAIT: begin
        if (qvalid_ok_c) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = (op_q == OP_REM) ? div_rem_c : div_quo_c;
          wb_rem_d   = div_rem_c;
          wb_zero_d  = (((op_q == OP_REM) ? div_rem_c : div_quo_c) == '0);
          wb_err_d   = 1'b0;
          state_d    = ST_HOLD;
        end else if (timer_tc_c) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = '1;
          wb_rem_d   = '0;
          wb_zero_d  = 1'b0;
          wb_err_d   = 1'b1;
          state_d    = ST_HOLD;
        end
      end

      ST_HOLD: begin
        if (WB_READY) begin
          wb_valid_d = 1'b0;
          wb_err_d   = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD;
      rd_q        <= '0;
      div_start_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= '0;
      wb_data_q   <= '0;
      wb_rem_q    <= '0;
      wb_zero_q   <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      div_start_q <= div_start_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      wb_rem_q    <= wb_rem_d;
      wb_zero_q   <= wb_zero_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign ISSUE_READY = (state_q == ST_IDLE);
  assign DIV_START   = div_start_q;
  assign WB_VALID    = wb_valid_q;
  assign WB_RD       = wb_rd_q;
  assign WB_DATA     = wb_data_q;
  assign WB_REM      = wb_rem_q;
  assign WB_ZERO     = wb_zero_q;
  assign WB_ERR      = wb_err_q;

endmodule

// File: tb/tb_alu_result_ctrl.sv
// Scoreboard bench for alu_result_ctrl: expected writebacks queued at issue,
// popped and compared at each WB handshake; per-scenario timing checks inline.
module tb_alu_result_ctrl;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] data;
    logic [15:0] rem;
    logic        zero;
    logic        err;
  } exp_t;

  logic        clk, rst_n;
  logic        issue_valid, issue_ready;
  logic [2:0]  issue_op;
  logic [3:0]  issue_rd;
  logic [15:0] s, d, p, and_o, or_o, xor_o;
  logic [31:0] div_q;
  logic        div_qvalid, div_start;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data, wb_rem;
  logic        wb_zero, wb_err;

  int   checks = 0;
  int   errors = 0;
  int   n_div_start = 0;
  exp_t sb[$];

  alu_result_ctrl dut (
    .CLK(clk), .RST_N(rst_n),
    .ISSUE_VALID(issue_valid), .ISSUE_READY(issue_ready),
    .ISSUE_OP(issue_op), .ISSUE_RD(issue_rd),
    .S(s), .D(d), .P(p), .AND_OUT(and_o), .OR_OUT(or_o), .XOR_OUT(xor_o),
    .DIV_Q(div_q), .DIV_QVALID(div_qvalid), .DIV_START(div_start),
    .WB_VALID(wb_valid), .WB_READY(wb_ready), .WB_RD(wb_rd),
    .WB_DATA(wb_data), .WB_REM(wb_rem), .WB_ZERO(wb_zero), .WB_ERR(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: compare each handshaken writeback against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_wb got rd=%h data=%h rem=%h zero=%b err=%b, required no writeback",
                 wb_rd, wb_data, wb_rem, wb_zero, wb_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({wb_rd, wb_data, wb_rem, wb_zero, wb_err} !== e) begin
          errors++;
          $display("FAIL sb_wb got rd=%h data=%h rem=%h zero=%b err=%b, required rd=%h data=%h rem=%h zero=%b err=%b",
                   wb_rd, wb_data, wb_rem, wb_zero, wb_err, e.rd, e.data, e.rem, e.zero, e.err);
        end
      end
    end
  end

  always @(negedge clk) if (div_start === 1'b1) n_div_start++;

  task automatic issue(input logic [2:0] op, input logic [3:0] rd);
    int n = 0;
    while (!issue_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready_timeout got %b, required 1", issue_ready);
    end
    issue_valid = 1'b1;
    issue_op    = op;
    issue_rd    = rd;
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!issue_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle_timeout got issue_ready=%b, required 1", tag, issue_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({issue_ready, div_start, wb_valid, wb_err, wb_zero} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags got rdy=%b ds=%b v=%b e=%b z=%b, required 1 0 0 0 0",
               issue_ready, div_start, wb_valid, wb_err, wb_zero);
    end
    checks++;
    if ({wb_rd, wb_data, wb_rem} !== 36'h0) begin
      errors++;
      $display("FAIL reset_data got rd=%h data=%h rem=%h, required 0", wb_rd, wb_data, wb_rem);
    end
  endtask

  task automatic test_add();
    wb_ready = 1'b1;
    s = 16'h01C1;
    sb.push_back('{rd: 4'd3, data: 16'h01C1, rem: 16'h0, zero: 1'b0, err: 1'b0});
    issue(3'd0, 4'd3);
    checks++;
    if (issue_ready !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_cycle0 got rdy=%b v=%b, required 0 0", issue_ready, wb_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (issue_ready !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 16'h01C1 || wb_zero !== 1'b0) begin
      errors++;
      $display("FAIL add_cycle1 got rdy=%b v=%b data=%h z=%b, required 0 1 01c1 0",
               issue_ready, wb_valid, wb_data, wb_zero);
    end
    @(posedge clk); #1;
    checks++;
    if (issue_ready !== 1'b1 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL add_cycle2 got rdy=%b v=%b, required 1 0", issue_ready, wb_valid);
    end
  endtask

  task automatic test_div(input logic [2:0] op, input logic [3:0] rd, input logic [15:0] exp_data);
    wb_ready   = 1'b1;
    div_q      = 32'h0024_0003;
    div_qvalid = 1'b0;
    sb.push_back('{rd: rd, data: exp_data, rem: 16'h0003, zero: 1'b0, err: 1'b0});
    issue(op, rd);
    checks++;
    if (div_start !== 1'b1) begin
      errors++;
      $display("FAIL div_start_pulse got %b, required 1", div_start);
    end
    @(posedge clk); #1;
    checks++;
    if (div_start !== 1'b0) begin
      errors++;
      $display("FAIL div_start_width got %b, required 0", div_start);
    end
    repeat (17) begin @(posedge clk); #1; end
    div_qvalid = 1'b1;
    @(posedge clk); #1;
    div_qvalid = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== exp_data || wb_rem !== 16'h0003) begin
      errors++;
      $display("FAIL div_capture got v=%b data=%h rem=%h, required 1 %h 0003",
               wb_valid, wb_data, wb_rem, exp_data);
    end
    wait_idle("div");
  endtask

  task automatic test_hold();
    wb_ready = 1'b0;
    xor_o = 16'h0000;
    sb.push_back('{rd: 4'd7, data: 16'h0, rem: 16'h0, zero: 1'b1, err: 1'b0});
    issue(3'd5, 4'd7);
    @(posedge clk); #1;
    xor_o = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wb_valid !== 1'b1 || wb_data !== 16'h0 || wb_zero !== 1'b1 || wb_rd !== 4'd7 || issue_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable[%0d] got v=%b data=%h z=%b rd=%h rdy=%b, required 1 0000 1 7 0",
                 i, wb_valid, wb_data, wb_zero, wb_rd, issue_ready);
      end
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release got v=%b rdy=%b, required 0 1", wb_valid, issue_ready);
    end
  endtask

  task automatic test_timeout();
    int early = 0;
    wb_ready   = 1'b1;
    div_qvalid = 1'b0;
    sb.push_back('{rd: 4'd9, data: 16'hFFFF, rem: 16'h0, zero: 1'b0, err: 1'b1});
    issue(3'd6, 4'd9);
    for (int i = 1; i < 24; i++) begin
      @(posedge clk); #1;
      if (wb_valid !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early got %0d early valid cycles, required 0", early);
    end
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_err !== 1'b1 || wb_data !== 16'hFFFF || wb_rem !== 16'h0) begin
      errors++;
      $display("FAIL timeout_err got v=%b e=%b data=%h rem=%h, required 1 1 ffff 0000",
               wb_valid, wb_err, wb_data, wb_rem);
    end
    wait_idle("timeout");
    or_o = 16'h5A5A;
    sb.push_back('{rd: 4'd10, data: 16'h5A5A, rem: 16'h0, zero: 1'b0, err: 1'b0});
    issue(3'd4, 4'd10);
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_err !== 1'b0 || wb_data !== 16'h5A5A) begin
      errors++;
      $display("FAIL timeout_next got v=%b e=%b data=%h, required 1 0 5a5a", wb_valid, wb_err, wb_data);
    end
    wait_idle("timeout_next");
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    wb_ready   = 1'b1;
    div_qvalid = 1'b0;
    div_q      = 32'h0BAD_0BAD;
    issue(3'd6, 4'd2);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({issue_ready, div_start, wb_valid, wb_err, wb_zero, wb_rd, wb_data, wb_rem} !== {5'b10000, 36'h0}) begin
      errors++;
      $display("FAIL reset_mid got rdy=%b ds=%b v=%b e=%b z=%b rd=%h data=%h rem=%h, required 1 0 0 0 0 0 0 0",
               issue_ready, div_start, wb_valid, wb_err, wb_zero, wb_rd, wb_data, wb_rem);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    div_qvalid = 1'b1;
    @(posedge clk); #1;
    div_qvalid = 1'b0;
    repeat (3) begin
      if (wb_valid !== 1'b0 || div_start !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_mid_stale got %0d cycles with valid/start, required 0", bad);
    end
    s = 16'h0005;
    sb.push_back('{rd: 4'd1, data: 16'h0005, rem: 16'h0, zero: 1'b0, err: 1'b0});
    issue(3'd0, 4'd1);
    @(posedge clk); #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 16'h0005) begin
      errors++;
      $display("FAIL reset_mid_add got v=%b data=%h, required 1 0005", wb_valid, wb_data);
    end
    wait_idle("reset_mid");
  endtask

  task automatic test_back_to_back();
    int starts0;
    wb_ready   = 1'b1;
    p          = 16'hFE01;
    div_q      = 32'hDEAD_BEEF;
    div_qvalid = 1'b1;
    starts0    = n_div_start;
    sb.push_back('{rd: 4'd1, data: 16'hFE01, rem: 16'h0, zero: 1'b0, err: 1'b0});
    issue(3'd2, 4'd1);
    sb.push_back('{rd: 4'd4, data: 16'h1234, rem: 16'h0056, zero: 1'b0, err: 1'b0});
    issue(3'd6, 4'd4);
    @(posedge clk); #1;
    div_q = 32'h1234_0056;
    @(posedge clk); #1;
    div_qvalid = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || wb_rd !== 4'd4 || wb_data !== 16'h1234 || wb_rem !== 16'h0056) begin
      errors++;
      $display("FAIL b2b_div got v=%b rd=%h data=%h rem=%h, required 1 4 1234 0056",
               wb_valid, wb_rd, wb_data, wb_rem);
    end
    wait_idle("b2b");
    checks++;
    if (n_div_start - starts0 != 1) begin
      errors++;
      $display("FAIL b2b_div_start_count got %0d, required 1", n_div_start - starts0);
    end
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_op = 3'd0; issue_rd = 4'd0;
    s = '0; d = 16'h1111; p = '0; and_o = 16'h2222; or_o = '0; xor_o = '0;
    div_q = '0; div_qvalid = 1'b0; wb_ready = 1'b1;
    repeat (2) @(posedge clk);
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_add();
    test_div(3'd6, 4'd5, 16'h0024);
    test_div(3'd7, 4'd6, 16'h0003);
    test_hold();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
